osd_text_render: RTL
====================

OSD_TEXT_RENDER -- requirements
Module: osd_text_render

Interface
REQ-001 The module SHALL have parameter BLANK_CODE, default 8'h20, the ASCII code substituted for any code >= 8'h80.
REQ-002 The module SHALL have parameter AUTO_REFRESH, default 1; when 1, any text write schedules a re-render.
REQ-003 pclk  in  1  sole clock; every register SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-high reset; asserted when 1 (the codebase naming is kept despite the polarity).
REQ-005 i_vs  in  1  video vertical sync, in the pclk domain; used only to time the commit.
REQ-006 txt_wr_en  in  1  text write strobe, single-cycle.
REQ-007 txt_wr_addr  in  5  character slot: line = addr[4], column = addr[3:0].
REQ-008 txt_wr_data  in  8  ASCII code for the slot.
REQ-009 update_req  in  1  single-cycle request for a re-render.
REQ-010 busy  out  1  high from leaving IDLE until the commit cycle, inclusive.
REQ-011 done  out  1  one-cycle pulse in the commit cycle.
REQ-012 char0..char31  out  128 each  bitmap rows 0..31 for the OSD overlay; pixel x maps to bit 127-x.

Function
REQ-013 Text storage SHALL be 32 x 8-bit registers; a write SHALL take effect on the next cycle.
REQ-014 A pending flag SHALL be set by update_req, or by txt_wr_en when AUTO_REFRESH=1; it SHALL be cleared on the IDLE->FETCH transition.
REQ-015 FSM states SHALL be IDLE, FETCH, WAIT, WRITE, WAIT_VS and COMMIT.
REQ-016 IDLE SHALL go to FETCH when pending=1.
REQ-017 FETCH SHALL issue the font address {code[6:0], glyph_row[3:0]} for the current slot, with the BLANK_CODE substitution applied.
REQ-018 WAIT SHALL cover the 1-cycle ROM latency.
REQ-019 WRITE SHALL store the ROM byte into shadow row line*16+glyph_row, bits [127-8*col : 120-8*col].
REQ-020 Iteration order SHALL be glyph_row-major within a slot, then col 0..15, then line 0..1.
REQ-021 After the 512th WRITE the FSM SHALL go to WAIT_VS.
REQ-022 A render SHALL take exactly 1536 cycles from IDLE exit to WAIT_VS entry.
REQ-023 WAIT_VS SHALL move to COMMIT on the first cycle where i_vs=1 and i_vs was 0 on the previous cycle.
REQ-024 COMMIT SHALL copy all 32 shadow rows to char0..char31 in one cycle, pulse done, and return to IDLE.
REQ-025 Outputs SHALL change only in COMMIT, so no partial frame is ever presented.
REQ-026 A text write during a render SHALL set pending; that render SHALL complete and commit, then the next render SHALL start from IDLE.
REQ-027 update_req and txt_wr_en in the same cycle SHALL set pending once; no double render.
REQ-028 An i_vs rising edge while not in WAIT_VS SHALL be ignored.

Reset
REQ-029 Reset SHALL clear char0..char31 and the shadow to 0, fill the text storage with BLANK_CODE, clear pending, busy and done, and put the FSM in IDLE.
REQ-030 Reset asserted mid-render SHALL abort the render immediately; no commit SHALL occur.

Configuration
REQ-031 With macro OSD_CURSOR_EN defined, inputs cursor_en (1 bit) and cursor_pos (5 bits) SHALL exist.
REQ-032 With OSD_CURSOR_EN defined and cursor_en=1, glyph_row 15 of slot cursor_pos SHALL be ORed with 8'hFF before the shadow write; cursor changes SHALL take effect only on the next render.
REQ-033 Without OSD_CURSOR_EN, those ports and that logic SHALL be absent, and the bitmap SHALL equal the pure font output.

Structure
REQ-034 Package osd_pkg SHALL hold: CHAR_COLS=16, TEXT_LINES=2, GLYPH_W=8, GLYPH_H=16, BMP_W=128, BMP_H=32, and the FSM state enum.
REQ-035 Sub-module font_rom_8x16 SHALL be a 2048 x 8 synchronous-read ROM (128 codes x 16 rows, MSB = leftmost pixel) with 1-cycle latency.

Verification
REQ-036 Reset, then update_req -> busy for 1536 cycles plus the wait for i_vs; after the i_vs rising edge, done pulses once and all char rows read 0 (blank glyph).
REQ-037 Write 8'h41 ('A') to slot 0, then render -> char[r][127:120] equals font row r of 'A' for r=0..15; all other bits are 0.
REQ-038 Write 8'h48 to slot 31 -> the glyph appears in char16..char31, bits [7:0]; char0..char15 are unchanged.
REQ-039 Text write at cycle 700 of a render -> the first render commits, a second render follows immediately, and done pulses twice.
REQ-040 Code 8'hC3 written -> renders identically to BLANK_CODE.
REQ-041 rst_n pulsed mid-render, then an i_vs edge -> no done pulse and outputs remain 0.
REQ-042 With OSD_CURSOR_EN defined, cursor_pos=5 and cursor_en=1 -> char15[87:80] = 8'hFF.

Source files
------------

// File: rtl/osd_pkg.sv
// Shared geometry, FSM state type and code-sanitising helper for the OSD text renderer.
package osd_pkg;

  localparam int CHAR_COLS    = 16;
  localparam int TEXT_LINES   = 2;
  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int BMP_W        = 128;
  localparam int BMP_H        = 32;
  localparam int SLOTS        = CHAR_COLS * TEXT_LINES;
  localparam int RENDER_STEPS = SLOTS * GLYPH_H;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    WRITE   = 3'd3,
    WAIT_VS = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  // The font only covers 7-bit ASCII; anything above is shown as the blank code.
  function automatic logic [6:0] glyph_code(input logic [7:0] code, input logic [7:0] blank);
    return code[7] ? blank[6:0] : code[6:0];
  endfunction

endpackage

// File: rtl/osd_text_render_font_rom.sv
// 2048 x 8 synchronous-read font ROM: 128 codes x 16 rows, MSB is the leftmost pixel.
module font_rom_8x16
  import osd_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  // Each glyph is packed row 0 first (bits 127:120) down to row 15 (bits 7:0).
  function automatic logic [127:0] glyph_bits(input logic [6:0] code);
    logic [127:0] g;
    case (code)
      7'h00:   g = 128'h00000000_00000000_00000000_00000000;
      7'h20:   g = 128'h00000000_00000000_00000000_00000000;
      7'h2D:   g = 128'h00000000_000000FE_00000000_00000000;
      7'h30:   g = 128'h00007CC6_C6CEDEF6_E6C6C67C_00000000;
      7'h31:   g = 128'h00001838_78181818_1818187E_00000000;
      7'h3A:   g = 128'h00000000_18180000_00181800_00000000;
      7'h41:   g = 128'h00001038_6CC6C6FE_C6C6C6C6_00000000;
      7'h45:   g = 128'h0000FE66_62687868_606266FE_00000000;
      7'h48:   g = 128'h0000C6C6_C6C6FEC6_C6C6C6C6_00000000;
      7'h4B:   g = 128'h0000E666_666C7878_6C6666E6_00000000;
      7'h4C:   g = 128'h0000F060_60606060_606266FE_00000000;
      7'h4F:   g = 128'h00007CC6_C6C6C6C6_C6C6C67C_00000000;
      // Codes without a designed glyph show a hollow box so they are visible on screen.
      default: g = 128'h0000FE82_82828282_828282FE_00000000;
    endcase
    return g;
  endfunction

  logic [127:0] bits;

  assign bits = glyph_bits(addr[10:4]);

  // Row r lives at bits [8*(15-r) +: 8]; ~r equals 15-r for a 4-bit row.
  always_ff @(posedge clk) begin
    data <= bits[{~addr[3:0], 3'b000} +: GLYPH_W];
  end

endmodule

// File: rtl/osd_text_render.sv
// Renders a 2x16 character text buffer into a 128x32 bitmap, committed on a vsync edge.
// Optional cursor underline is enabled by defining OSD_CURSOR_EN.
module osd_text_render
  import osd_pkg::*;
#(
  parameter logic [7:0] BLANK_CODE   = 8'h20,
  parameter int         AUTO_REFRESH = 1
)
(
  input  logic         pclk,
  input  logic         rst_n,
  input  logic         i_vs,
  input  logic         txt_wr_en,
  input  logic [4:0]   txt_wr_addr,
  input  logic [7:0]   txt_wr_data,
  input  logic         update_req,
`ifdef OSD_CURSOR_EN
  input  logic         cursor_en,
  input  logic [4:0]   cursor_pos,
`endif
  output logic         busy,
  output logic         done,
  output logic [127:0] char0,
  output logic [127:0] char1,
  output logic [127:0] char2,
  output logic [127:0] char3,
  output logic [127:0] char4,
  output logic [127:0] char5,
  output logic [127:0] char6,
  output logic [127:0] char7,
  output logic [127:0] char8,
  output logic [127:0] char9,
  output logic [127:0] char10,
  output logic [127:0] char11,
  output logic [127:0] char12,
  output logic [127:0] char13,
  output logic [127:0] char14,
  output logic [127:0] char15,
  output logic [127:0] char16,
  output logic [127:0] char17,
  output logic [127:0] char18,
  output logic [127:0] char19,
  output logic [127:0] char20,
  output logic [127:0] char21,
  output logic [127:0] char22,
  output logic [127:0] char23,
  output logic [127:0] char24,
  output logic [127:0] char25,
  output logic [127:0] char26,
  output logic [127:0] char27,
  output logic [127:0] char28,
  output logic [127:0] char29,
  output logic [127:0] char30,
  output logic [127:0] char31
);

  state_t           state, state_nxt;
  logic [7:0]       text [SLOTS];
  logic             pending;
  logic             pending_set;
  logic             vs_d;
  logic             vs_rise;
  logic [8:0]       idx;
  logic [10:0]      rom_addr_p0;
  logic [7:0]       rom_data_p1;
  logic             cur_hit;
  logic [7:0]       glyph_byte;
  logic [BMP_W-1:0] shadow [BMP_H];
  logic [BMP_W-1:0] disp   [BMP_H];

  // idx walks {line, col, glyph_row} so glyph rows are innermost, then columns, then lines.
  assign pending_set = update_req | ((AUTO_REFRESH != 0) && txt_wr_en);
  assign vs_rise     = i_vs & ~vs_d;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == COMMIT);
    case (state)
      IDLE:    if (pending) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = WRITE;
      WRITE:   state_nxt = (idx == 9'(RENDER_STEPS - 1)) ? WAIT_VS : FETCH;
      WAIT_VS: if (vs_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      vs_d    <= 1'b0;
      idx     <= '0;
    end else begin
      state <= state_nxt;
      vs_d  <= i_vs;
      // A request arriving on the launch cycle wins, so it is never lost.
      if (pending_set)
        pending <= 1'b1;
      else if (state == IDLE && pending)
        pending <= 1'b0;
      if (state == IDLE)
        idx <= '0;
      else if (state == WRITE)
        idx <= idx + 9'd1;
    end
  end

  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      for (int s = 0; s < SLOTS; s++) text[s] <= BLANK_CODE;
    end else if (txt_wr_en) begin
      text[txt_wr_addr] <= txt_wr_data;
    end
  end

  // Stage p0: FETCH registers the font address for the current slot and glyph row.
  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n)
      rom_addr_p0 <= '0;
    else if (state == FETCH)
      rom_addr_p0 <= {glyph_code(text[idx[8:4]], BLANK_CODE), idx[3:0]};
  end

  // Stage p1: ROM byte is valid during WRITE (WAIT absorbs the read latency).
  font_rom_8x16 u_font (
    .clk  (pclk),
    .addr (rom_addr_p0),
    .data (rom_data_p1)
  );

`ifdef OSD_CURSOR_EN
  logic       cur_en_q;
  logic [4:0] cur_pos_q;

  // Cursor is sampled at render launch so a moving cursor never tears a frame.
  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      cur_en_q  <= 1'b0;
      cur_pos_q <= '0;
    end else if (state == IDLE && pending) begin
      cur_en_q  <= cursor_en;
      cur_pos_q <= cursor_pos;
    end
  end

  assign cur_hit = cur_en_q && (cur_pos_q == idx[8:4]) && (idx[3:0] == 4'hF);
`else
  assign cur_hit = 1'b0;
`endif

  assign glyph_byte = rom_data_p1 | {8{cur_hit}};

  // Stage p2: shadow row is line*16+glyph_row; column c occupies bits [8*(15-c) +: 8].
  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      for (int r = 0; r < BMP_H; r++) shadow[r] <= '0;
    end else if (state == WRITE) begin
      shadow[{idx[8], idx[3:0]}][{~idx[7:4], 3'b000} +: GLYPH_W] <= glyph_byte;
    end
  end

  always_ff @(posedge pclk or posedge rst_n) begin
    if (rst_n) begin
      for (int r = 0; r < BMP_H; r++) disp[r] <= '0;
    end else if (state == COMMIT) begin
      for (int r = 0; r < BMP_H; r++) disp[r] <= shadow[r];
    end
  end

  assign char0  = disp[0];
  assign char1  = disp[1];
  assign char2  = disp[2];
  assign char3  = disp[3];
  assign char4  = disp[4];
  assign char5  = disp[5];
  assign char6  = disp[6];
  assign char7  = disp[7];
  assign char8  = disp[8];
  assign char9  = disp[9];
  assign char10 = disp[10];
  assign char11 = disp[11];
  assign char12 = disp[12];
  assign char13 = disp[13];
  assign char14 = disp[14];
  assign char15 = disp[15];
  assign char16 = disp[16];
  assign char17 = disp[17];
  assign char18 = disp[18];
  assign char19 = disp[19];
  assign char20 = disp[20];
  assign char21 = disp[21];
  assign char22 = disp[22];
  assign char23 = disp[23];
  assign char24 = disp[24];
  assign char25 = disp[25];
  assign char26 = disp[26];
  assign char27 = disp[27];
  assign char28 = disp[28];
  assign char29 = disp[29];
  assign char30 = disp[30];
  assign char31 = disp[31];

endmodule
